// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte producers.
// Each grant accepts one byte, raises tx_start until the transmitter reports busy,
// then waits for the frame to finish before the next arbitration.
module uart_tx_arbiter #(
    parameter  int unsigned NUM_REQ       = 4,
    parameter  int unsigned DATA_WIDTH    = 8,
    parameter  int unsigned START_TIMEOUT = 8192,
    localparam int unsigned GW            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          tx_start,
    output logic [DATA_WIDTH-1:0]         tx_data,
    input  logic                          tx_busy,
    output logic [GW-1:0]                 grant_id,
    output logic                          active,
    output logic                          timeout_err
);

    localparam int unsigned CW = $clog2(START_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t                  state_q;
    logic [NUM_REQ-1:0]      req_ready_q;
    logic                    tx_start_q;
    logic [DATA_WIDTH-1:0]   tx_data_q;
    logic [GW-1:0]           grant_id_q;
    logic [GW-1:0]           last_grant_q;
    logic                    active_q;
    logic                    timeout_err_q;
    logic [CW-1:0]           cnt_q;

    logic                    win_found_c;
    logic [GW-1:0]           win_idx_c;
    logic [DATA_WIDTH-1:0]   win_data_c;

    // Round-robin search: first valid requester after last_grant, wrapping.
    always_comb begin
        int unsigned idx;
        idx         = 0;
        win_found_c = 1'b0;
        win_idx_c   = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = 32'(last_grant_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!win_found_c && req_valid[idx[GW-1:0]]) begin
                win_found_c = 1'b1;
                win_idx_c   = idx[GW-1:0];
            end
        end
    end

    // Byte of the current arbitration winner.
    always_comb begin
        win_data_c = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (win_idx_c == GW'(i)) begin
                win_data_c = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Arbitration / launch / completion state machine with registered outputs.
    // cnt_q counts cycles tx_start has already been held, so tx_start stays
    // high for exactly START_TIMEOUT cycles before a launch is aborted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            req_ready_q   <= '0;
            tx_start_q    <= 1'b0;
            tx_data_q     <= '0;
            grant_id_q    <= '0;
            last_grant_q  <= GW'(NUM_REQ - 1);
            active_q      <= 1'b0;
            timeout_err_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            req_ready_q   <= '0;
            timeout_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    tx_start_q <= 1'b0;
                    if (!tx_busy && win_found_c) begin
                        req_ready_q  <= NUM_REQ'(1) << win_idx_c;
                        tx_data_q    <= win_data_c;
                        grant_id_q   <= win_idx_c;
                        last_grant_q <= win_idx_c;
                        active_q     <= 1'b1;
                        cnt_q        <= '0;
                        state_q      <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    if (tx_busy) begin
                        tx_start_q <= 1'b0;
                        state_q    <= WAIT_DONE;
                    end else if (tx_start_q && (cnt_q == CW'(START_TIMEOUT - 1))) begin
                        tx_start_q    <= 1'b0;
                        timeout_err_q <= 1'b1;
                        active_q      <= 1'b0;
                        state_q       <= IDLE;
                    end else begin
                        tx_start_q <= 1'b1;
                        if (tx_start_q) begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                WAIT_DONE: begin
                    tx_start_q <= 1'b0;
                    if (!tx_busy) begin
                        active_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: begin
                    tx_start_q <= 1'b0;
                    active_q   <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign req_ready   = req_ready_q;
    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign grant_id    = grant_id_q;
    assign active      = active_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural UART_TX/RX loopback model
// and a scoreboard of expected grants and received bytes.
module tb_uart_tx_arbiter;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned DW      = 8;
    localparam int unsigned STO     = 16;
    localparam int unsigned FRAME   = 10;

    typedef struct {
        int         id;
        logic [7:0] data;
    } grant_t;

    logic                 clk;
    logic                 rst;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*DW-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx_start;
    logic [DW-1:0]        tx_data;
    logic                 tx_busy;
    logic [1:0]           grant_id;
    logic                 active;
    logic                 timeout_err;

    logic                 connected;
    logic                 force_busy;
    logic                 m_busy;
    logic [7:0]           m_cnt;
    logic [7:0]           m_byte;
    logic                 rx_valid;
    logic [7:0]           rx_byte;

    grant_t               exp_q[$];
    logic [7:0]           rx_q[$];
    int                   n_checks;
    int                   n_err;

    uart_tx_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .DATA_WIDTH   (DW),
        .START_TIMEOUT(STO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_busy    (tx_busy),
        .grant_id   (grant_id),
        .active     (active),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // UART_TX model: start accepted when idle, busy for FRAME cycles, byte looped to RX.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy   <= 1'b0;
            m_cnt    <= '0;
            m_byte   <= '0;
            rx_valid <= 1'b0;
            rx_byte  <= '0;
        end else begin
            rx_valid <= 1'b0;
            if (m_busy) begin
                if (m_cnt == 8'd1) begin
                    m_busy   <= 1'b0;
                    rx_valid <= 1'b1;
                    rx_byte  <= m_byte;
                end
                m_cnt <= m_cnt - 8'd1;
            end else if (connected && tx_start) begin
                m_busy <= 1'b1;
                m_cnt  <= 8'(FRAME);
                m_byte <= tx_data;
            end
        end
    end

    assign tx_busy = force_busy | (connected & m_busy);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every grant and every looped-back byte must match the head of its queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (req_ready != '0) begin
                chk("ready_onehot", 32'($onehot(req_ready)), 32'd1);
                if (exp_q.size() == 0) begin
                    chk("grant_unexpected", 32'(req_ready), 32'd0);
                end else begin
                    grant_t e;
                    e = exp_q.pop_front();
                    chk("grant_id", 32'(grant_id), 32'(e.id));
                    chk("grant_ready", 32'(req_ready), 32'(1) << e.id);
                    chk("grant_data", 32'(tx_data), 32'(e.data));
                end
            end
            if (rx_valid) begin
                if (rx_q.size() == 0) begin
                    chk("rx_unexpected", 32'(rx_byte), 32'hFFFF);
                end else begin
                    logic [7:0] b;
                    b = rx_q.pop_front();
                    chk("rx_byte", 32'(rx_byte), 32'(b));
                end
            end
        end
    end

    task automatic push(input int id, input logic [7:0] d, input bit rx);
        grant_t g;
        g.id   = id;
        g.data = d;
        exp_q.push_back(g);
        if (rx) rx_q.push_back(d);
    endtask

    task automatic wait_grants(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("wait_grants_budget", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((active || tx_busy || rx_q.size() != 0) && n < budget) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("wait_idle", {30'd0, active, tx_busy}, 32'd0);
        rx_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    function automatic logic [31:0] outs_packed();
        return {8'd0, tx_start, active, timeout_err, 1'b0, req_ready, 2'd0, grant_id, tx_data};
    endfunction

    initial begin
        int n;
        int cnt_start;
        bit saw_busy;
        bit saw_to;

        n_checks   = 0;
        n_err      = 0;
        rst        = 1'b1;
        req_valid  = '0;
        req_data   = {8'hC3, 8'h3C, 8'hAA, 8'h55};
        connected  = 1'b1;
        force_busy = 1'b0;

        // Reset values
        @(posedge clk);
        #1 chk("reset_outputs", outs_packed(), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single source on requester 2
        req_data[2*DW +: DW] = 8'hA5;
        push(2, 8'hA5, 1'b1);
        req_valid = 4'b0100;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (req_ready == '0 && n < 50);
        chk("single_ready", 32'(req_ready), 32'h4);
        @(posedge clk);
        #1;
        chk("single_ready_pulse", 32'(req_ready), 32'd0);
        chk("single_tx_start", 32'(tx_start), 32'd1);
        chk("single_active", 32'(active), 32'd1);
        req_valid = '0;
        saw_busy = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            if (tx_busy) saw_busy = 1'b1;
            n++;
        end while (active && n < 100);
        chk("single_saw_busy", 32'(saw_busy), 32'd1);
        chk("single_active_after_busy", {30'd0, active, tx_busy}, 32'd0);
        wait_idle(50);
        req_data[2*DW +: DW] = 8'h3C;

        // All four requesters held valid: eight frames in strict rotation
        do_reset();
        for (int r = 0; r < 2; r++) begin
            push(0, 8'h55, 1'b1);
            push(1, 8'hAA, 1'b1);
            push(2, 8'h3C, 1'b1);
            push(3, 8'hC3, 1'b1);
        end
        req_valid = 4'hF;
        wait_grants(400);
        req_valid = '0;
        wait_idle(100);

        // Rotation: req1 in flight, then req0 and req3 raised together
        push(1, 8'hAA, 1'b1);
        req_valid = 4'b0010;
        wait_grants(50);
        push(3, 8'hC3, 1'b1);
        push(0, 8'h55, 1'b1);
        req_valid = 4'b1001;
        wait_grants(200);
        req_valid = '0;
        wait_idle(100);

        // Launch timeout with the transmitter disconnected
        connected = 1'b0;
        push(0, 8'h55, 1'b0);
        req_valid = 4'b0001;
        wait_grants(50);
        push(2, 8'h3C, 1'b1);
        req_valid = 4'b0101;
        cnt_start = 0;
        saw_to = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            if (tx_start) cnt_start++;
            if (timeout_err) saw_to = 1'b1;
            n++;
        end while (!saw_to && n < 100);
        connected = 1'b1;
        chk("timeout_pulse", 32'(saw_to), 32'd1);
        chk("timeout_start_cycles", 32'(cnt_start), 32'(STO));
        chk("timeout_idle_outs", {30'd0, tx_start, active}, 32'd0);
        @(posedge clk);
        #1 chk("timeout_single_cycle", 32'(timeout_err), 32'd0);
        wait_grants(50);
        req_valid = '0;
        wait_idle(100);

        // Async reset in LAUNCH
        connected = 1'b0;
        push(3, 8'hC3, 1'b0);
        req_valid = 4'hF;
        wait_grants(50);
        @(posedge clk);
        #3;
        chk("pre_reset_launch", {30'd0, tx_start, active}, 32'd3);
        rst = 1'b1;
        #1 chk("reset_mid_launch", outs_packed(), 32'd0);
        connected = 1'b1;
        push(0, 8'h55, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        wait_grants(50);

        // Async reset in WAIT_DONE
        n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (!(tx_busy && !tx_start && active) && n < 50);
        chk("pre_reset_wait_done", {29'd0, tx_busy, tx_start, active}, 32'd5);
        #1 rst = 1'b1;
        #1 chk("reset_mid_wait_done", outs_packed(), 32'd0);
        push(0, 8'h55, 1'b1);
        @(posedge clk);
        #1 rst = 1'b0;
        wait_grants(50);
        req_valid = '0;
        wait_idle(100);

        // Foreign busy in IDLE blocks every grant
        do_reset();
        force_busy = 1'b1;
        req_valid  = 4'hF;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready != '0 || active) n++;
        end
        chk("blocked_no_grant", 32'(n), 32'd0);
        push(0, 8'h55, 1'b1);
        force_busy = 1'b0;
        wait_grants(50);
        req_valid = '0;
        wait_idle(100);

        chk("grant_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("rx_queue_empty", 32'(rx_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
